to_lower_stream: RTL
====================

// Module: to_lower_stream
// PURPOSE
//   Streaming ASCII lower-case converter; inverse companion of the upper-case converter.
//   Bytes arrive on a valid/ready input and leave on a valid/ready output.
//   'A'..'Z' (8'h41..8'h5A) are converted by setting bit 5; all other bytes pass through unchanged.
//   Strings are delimited by in_last. Per string, the block reports the number of bytes it converted.
//   Sits between a character source (UART RX / string ROM) and the text sink.
// PARAMETERS
//   CW     8   width of per-string conversion counter (saturating)
//   DEPTH  2   output buffer entries (fixed at 2: skid buffer)
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   in_valid    in   1   in_data/in_last valid
//   in_ready    out  1   block can accept a byte this cycle
//   in_data     in   8   ASCII byte
//   in_last     in   1   final byte of current string
//   out_valid   out  1   out_data/out_last valid
//   out_ready   in   1   sink accepts output this cycle
//   out_data    out  8   converted byte
//   out_last    out  1   final byte of string
//   conv_count  out  CW  converted-byte count of last completed string
//   count_valid out  1   1-cycle pulse: conv_count updated
//   busy        out  1   string in progress or buffer non-empty
// BEHAVIOUR
//   Reset (async, rst=1): buffer emptied, state IDLE, internal counter 0.
//     Outputs during reset: in_ready=0, out_valid=0, out_data=0, out_last=0,
//       conv_count=0, count_valid=0, busy=0.
//     Reset mid-string discards buffered bytes and the partial count; no count_valid is emitted.
//     in_ready=1 from the first clock edge after rst deasserts.
//   Handshake rules:
//     Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
//     out_data/out_last are held stable while out_valid=1 and out_ready=0.
//   Buffer: 2-entry FIFO of {last,data}, conversion applied on write.
//     in_ready = (entries<2), driven from registers only, no combinational path from out_ready.
//     Latency: a byte accepted at edge N gives out_valid=1 after edge N (1 cycle) when the buffer was empty.
//     Throughput 1 byte/cycle with out_ready held 1.
//     Simultaneous push+pop while full is not possible (in_ready=0).
//     Push+pop at 1 entry leaves the entry count at 1.
//   Conversion: out = (in>=8'h41 && in<=8'h5A) ? in|8'h20 : in.
//     8'h40 '@', 8'h5B '[', 8'hC1 and all bytes with bit7=1 are unchanged.
//   FSM (two states):
//     IDLE:   accept without last -> ACTIVE, cnt = conv?1:0.
//             Accept with last -> stays IDLE, single-byte string, count reported.
//     ACTIVE: accept without last -> cnt += conv (saturate at 2^CW-1).
//             Accept with last -> IDLE; report count including this byte.
//     Report: conv_count <= final count; count_valid=1 for exactly the cycle after the last-byte accept.
//     conv_count holds until the next report; the internal counter then clears.
//   busy = (state==ACTIVE) | (entries!=0).
// TESTING
//   Directed scenarios (each: stimulus -> required response):
//   1. "Hello" (48 65 6C 6C 6F, last on 6F), out_ready=1 -> out 68 65 6C 6C 6F;
//      out_last on 6F; conv_count=1 pulse; 1-cycle latency.
//   2. Boundaries 40 41 5A 5B 60 7B C1 (last on C1) -> 40 61 7A 5B 60 7B C1; conv_count=2.
//   3. Backpressure: out_ready=0 while streaming "ABC" -> in_ready=0 after 2 accepts;
//      out holds 61; on release, 61 62 63 in order, no loss or duplication.
//   4. Saturation, CW=8: 300 x 'Z' with last on the 300th -> every out=7A; conv_count=255.
//   5. Reset: assert rst after 3 bytes of "ABCDE" -> outputs 0 immediately; no count_valid.
//      Then string "Q"(last) -> out 71; conv_count=1.
//   6. Single-byte strings back-to-back: 41(last), 31(last) ->
//      count_valid pulses on consecutive-accept cycles with conv_count 1 then 0.

Source files
------------

// File: rtl/to_lower_stream.sv
// Streaming ASCII lower-case converter with a 2-entry skid buffer and a
// per-string count of converted bytes, reported when the string's last byte is accepted.
module to_lower_stream #(
    parameter int CW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [CW-1:0] conv_count,
    output logic          count_valid,
    output logic          busy
);
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } ent_t;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;
    localparam logic [1:0] FULL     = 2'(DEPTH);

    ent_t          mem [2];
    logic          wp, rp;
    logic [1:0]    entries, entries_n;
    logic          rdy_q;
    logic [0:0]    state;
    logic [CW-1:0] cnt, base, sum;
    logic          push, pop, is_upper;
    logic [7:0]    conv_data;

    assign is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign conv_data = is_upper ? (in_data | 8'h20) : in_data;

    assign push = in_valid & rdy_q;
    assign pop  = out_valid & out_ready;

    always_comb begin
        entries_n = entries;
        if (push && !pop)
            entries_n = entries + 2'd1;
        else if (pop && !push)
            entries_n = entries - 2'd1;
    end

    // in_ready comes straight from a flop so out_ready never reaches the input side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            entries <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            if (push) begin
                mem[wp] <= '{last: in_last, data: conv_data};
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            entries <= entries_n;
            rdy_q   <= (entries_n != FULL);
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (entries != 2'd0);
    assign out_data  = mem[rp].data;
    assign out_last  = mem[rp].last;

    // A string's first byte starts from zero regardless of the stale counter
    assign base = (state == S_IDLE) ? '0 : cnt;
    assign sum  = (is_upper && base != '1) ? base + CW'(1) : base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            conv_count  <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (push) begin
                if (in_last) begin
                    conv_count  <= sum;
                    count_valid <= 1'b1;
                    cnt         <= '0;
                    state       <= S_IDLE;
                end else begin
                    cnt   <= sum;
                    state <= S_ACTIVE;
                end
            end
        end
    end

    assign busy = (state == S_ACTIVE) | (entries != 2'd0);
endmodule
